nrisc_call_stack: RTL and testbench
===================================

// Module: nrisc_call_stack
// PURPOSE
//  Parametrised hardware call/return stack for the NRISC CPU; holds return PC plus ULA flags per entry.
//  Driven by the core's stack control on CALL/RET, feeding the PC mux and the core's flag input.
//  Generalises the fixed 16-bit PC path to any width and depth, with selectable overflow mode.
//  Adds occupancy reporting and sticky error status.
// PARAMETERS
//  TAM       16  PC/address width in bits
//  DEPTH     8   number of entries, power of two, >=2
//  OVF_WRAP  0   0: push when full is dropped; 1: push when full overwrites the oldest entry (circular)
// PORTS
//  clk        in   1                 main clock, rising edge
//  rst        in   1                 asynchronous, active-low reset
//  push       in   1                 CALL: store pc_in/flags_in as new top
//  pop        in   1                 RET: remove top, present it on pc_out/flags_out
//  pc_in      in   TAM               return address to store (PC+1 from core)
//  flags_in   in   3                 ULA flags to store
//  err_clr    in   1                 clears sticky overflow/underflow
//  pc_out     out  TAM               last popped return address
//  flags_out  out  3                 last popped flags
//  pop_valid  out  1                 one-cycle pulse: pc_out/flags_out updated by a pop
//  count      out  $clog2(DEPTH)+1   entries held, 0..DEPTH
//  empty      out  1                 count==0 (combinational from count)
//  full       out  1                 count==DEPTH (combinational from count)
//  overflow   out  1                 sticky: push while full
//  underflow  out  1                 sticky: pop while empty
// BEHAVIOUR
//  - Reset (rst=0, async): count=0, internal top pointer=0, pc_out=0, flags_out=0, pop_valid=0,
//    overflow=0, underflow=0; RAM contents undefined, never read before written.
//  - All state changes on rising clk; one operation resolved per cycle.
//  - push only, not full: mem[top]<=pc_in/flags_in; top<=top+1 mod DEPTH; count+1.
//  - push only, full, OVF_WRAP=0: no write, count unchanged, overflow<=1.
//  - push only, full, OVF_WRAP=1: write at top (overwrites oldest), top+1 mod DEPTH, count stays DEPTH, overflow<=1.
//  - pop only, not empty: pc_out/flags_out<=mem[top-1]; top-1 mod DEPTH; count-1; pop_valid=1 next cycle.
//  - pop only, empty: outputs hold, count stays 0, underflow<=1, pop_valid stays 0.
//  - push&pop, not empty: pc_out/flags_out<=old top; mem[top-1]<=pc_in/flags_in (replace); count unchanged; pop_valid=1.
//  - push&pop, empty: treated as push only; underflow<=1; pop_valid=0.
//  - Latency: popped value visible on pc_out 1 cycle after pop edge; pushed value poppable next cycle.
//  - Pointer wrap: top is log2(DEPTH) bits, wraps naturally; count saturates at DEPTH, never wraps.
//  - err_clr: clears sticky bits; a new error in the same cycle wins (bit stays/sets 1).
//  - pop_valid is high exactly one cycle per successful pop; deasserts otherwise.
//  - Reset mid-operation: asynchronous, discards all entries; in-flight push/pop lost.
// CONFIGURATION
//  NRISC_STACK_FLAGS_EN defined: each entry is TAM+3 bits; flags_out returns stored flags.
//  NRISC_STACK_FLAGS_EN undefined: entries are TAM bits; flags_in ignored; flags_out held at 3'b000.
//  Port list identical in both builds.
// TESTING
//  1 reset: rst low mid-run -> count=0, empty=1, pc_out=0, overflow=underflow=0 immediately (async).
//  2 LIFO: push 0x0010,0x0020,0x0030 then 3 pops -> pc_out 0x0030,0x0020,0x0010, each with pop_valid pulse, empty=1 after.
//  3 overflow DEPTH=8, OVF_WRAP=0: push 1..9 -> full=1, overflow=1, 8 pops return 8..1.
//    OVF_WRAP=1: same stimulus -> 8 pops return 9..2.
//  4 underflow: pop when empty -> underflow=1, pop_valid=0, pc_out unchanged; err_clr -> underflow=0.
//  5 push&pop: stack holds 0x0100, push 0x0200 with pop -> pc_out=0x0100, count=1, next pop -> 0x0200.
//  6 flags: with NRISC_STACK_FLAGS_EN push flags 3'b101, pop -> flags_out=3'b101; without -> flags_out=3'b000.

Source files
------------

// File: rtl/nrisc_call_stack_if.sv
// Core-side bus of the NRISC call/return stack: CALL/RET controls, return PC/flags, status.
interface nrisc_call_stack_if #(
    parameter int unsigned TAM   = 16,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          push;
    logic          pop;
    logic [TAM-1:0] pc_in;
    logic [2:0]    flags_in;
    logic          err_clr;
    logic [TAM-1:0] pc_out;
    logic [2:0]    flags_out;
    logic          pop_valid;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    modport master (
        output push, pop, pc_in, flags_in, err_clr,
        input  pc_out, flags_out, pop_valid, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, pc_in, flags_in, err_clr,
        output pc_out, flags_out, pop_valid, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/nrisc_call_stack.sv
// Hardware call/return stack holding return PC (and optionally ULA flags) per entry.
// Define NRISC_STACK_FLAGS_EN to store and return flags alongside the PC.
module nrisc_call_stack #(
    parameter int unsigned TAM      = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned OVF_WRAP = 0
) (
    input logic              clk,
    input logic              rst,
    nrisc_call_stack_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
`ifdef NRISC_STACK_FLAGS_EN
    localparam int unsigned EW = TAM + 3;
`else
    localparam int unsigned EW = TAM;
`endif

    logic [EW-1:0]  mem [DEPTH];
    logic [PW-1:0]  top;
    logic [PW-1:0]  top_m1;
    logic [CW-1:0]  count;
    logic [TAM-1:0] pc_q;
    logic [2:0]     flags_q;
    logic           pop_valid_q;
    logic           overflow_q;
    logic           underflow_q;
    logic           is_empty;
    logic           is_full;
    logic           we;
    logic [PW-1:0]  waddr;
    logic [EW-1:0]  wdata;
    logic [EW-1:0]  rdata;

    assign top_m1   = top - PW'(1);
    assign is_empty = (count == CW'(0));
    assign is_full  = (count == CW'(DEPTH));
    assign rdata    = mem[top_m1];

`ifdef NRISC_STACK_FLAGS_EN
    assign wdata = {bus.flags_in, bus.pc_in};
`else
    logic unused_flags;
    assign wdata        = bus.pc_in;
    assign unused_flags = ^bus.flags_in;
`endif

    // Write port: push&pop on a non-empty stack replaces the top in place
    always_comb begin
        we    = 1'b0;
        waddr = top;
        if (bus.push) begin
            if (bus.pop && !is_empty) begin
                we    = 1'b1;
                waddr = top_m1;
            end else if (!is_full || (OVF_WRAP != 0)) begin
                we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Pointer, occupancy, popped value and sticky errors; err_clr loses to a new error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top         <= '0;
            count       <= '0;
            pc_q        <= '0;
            flags_q     <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pop_valid_q <= 1'b0;
            if (bus.err_clr) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end
            if (bus.push && bus.pop && !is_empty) begin
                pc_q        <= rdata[TAM-1:0];
`ifdef NRISC_STACK_FLAGS_EN
                flags_q     <= rdata[TAM +: 3];
`endif
                pop_valid_q <= 1'b1;
            end else if (bus.push) begin
                if (bus.pop) underflow_q <= 1'b1;
                if (!is_full) begin
                    top   <= top + PW'(1);
                    count <= count + CW'(1);
                end else begin
                    overflow_q <= 1'b1;
                    if (OVF_WRAP != 0) top <= top + PW'(1);
                end
            end else if (bus.pop) begin
                if (!is_empty) begin
                    pc_q        <= rdata[TAM-1:0];
`ifdef NRISC_STACK_FLAGS_EN
                    flags_q     <= rdata[TAM +: 3];
`endif
                    pop_valid_q <= 1'b1;
                    top         <= top_m1;
                    count       <= count - CW'(1);
                end else begin
                    underflow_q <= 1'b1;
                end
            end
        end
    end

    assign bus.pc_out    = pc_q;
    assign bus.flags_out = flags_q;
    assign bus.pop_valid = pop_valid_q;
    assign bus.count     = count;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_nrisc_call_stack.sv
// Directed self-checking bench for nrisc_call_stack; a drop-mode and a wrap-mode stack see identical stimulus.
module tb_nrisc_call_stack;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    nrisc_call_stack_if #(.TAM(16), .DEPTH(8)) a_if ();
    nrisc_call_stack_if #(.TAM(16), .DEPTH(8)) w_if ();

    nrisc_call_stack #(.TAM(16), .DEPTH(8), .OVF_WRAP(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    nrisc_call_stack #(.TAM(16), .DEPTH(8), .OVF_WRAP(1)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (w_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef NRISC_STACK_FLAGS_EN
    localparam logic [2:0] EXP_FL = 3'b101;
`else
    localparam logic [2:0] EXP_FL = 3'b000;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic p, input logic q, input logic [15:0] pc,
                          input logic [2:0] fl, input logic clr);
        a_if.push = p; a_if.pop = q; a_if.pc_in = pc; a_if.flags_in = fl; a_if.err_clr = clr;
        w_if.push = p; w_if.pop = q; w_if.pc_in = pc; w_if.flags_in = fl; w_if.err_clr = clr;
    endtask

    // One clocked operation; outputs are sampled 1 time unit after the edge
    task automatic op(input logic p, input logic q, input logic [15:0] pc,
                      input logic [2:0] fl, input logic clr);
        set_in(p, q, pc, fl, clr);
        @(posedge clk);
        #1;
        set_in(1'b0, 1'b0, 16'h0, 3'b000, 1'b0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        set_in(1'b0, 1'b0, 16'h0, 3'b000, 1'b0);
        #2;
        chk("rst_count", 32'(a_if.count), 32'd0);
        chk("rst_empty", 32'(a_if.empty), 32'd1);
        chk("rst_full", 32'(a_if.full), 32'd0);
        chk("rst_pc", 32'(a_if.pc_out), 32'd0);
        chk("rst_pv", 32'(a_if.pop_valid), 32'd0);
        chk("rst_err", 32'({a_if.overflow, a_if.underflow}), 32'd0);
        #10 rst = 1'b1;

        // LIFO order
        op(1'b1, 1'b0, 16'h0010, 3'b000, 1'b0);
        op(1'b1, 1'b0, 16'h0020, 3'b000, 1'b0);
        op(1'b1, 1'b0, 16'h0030, 3'b000, 1'b0);
        chk("lifo_count3", 32'(a_if.count), 32'd3);
        chk("lifo_pv_idle", 32'(a_if.pop_valid), 32'd0);
        op(1'b0, 1'b1, 16'h0, 3'b000, 1'b0);
        chk("lifo_pop1", 32'(a_if.pc_out), 32'h30);
        chk("lifo_pv1", 32'(a_if.pop_valid), 32'd1);
        chk("lifo_count2", 32'(a_if.count), 32'd2);
        op(1'b0, 1'b1, 16'h0, 3'b000, 1'b0);
        chk("lifo_pop2", 32'(a_if.pc_out), 32'h20);
        chk("lifo_pv2", 32'(a_if.pop_valid), 32'd1);
        op(1'b0, 1'b1, 16'h0, 3'b000, 1'b0);
        chk("lifo_pop3", 32'(a_if.pc_out), 32'h10);
        chk("lifo_pop3_w", 32'(w_if.pc_out), 32'h10);
        chk("lifo_empty", 32'(a_if.empty), 32'd1);
        op(1'b0, 1'b0, 16'h0, 3'b000, 1'b0);
        chk("lifo_pv_drop", 32'(a_if.pop_valid), 32'd0);

        // Underflow and clear
        op(1'b0, 1'b1, 16'h0, 3'b000, 1'b0);
        chk("unf_set", 32'(a_if.underflow), 32'd1);
        chk("unf_pv", 32'(a_if.pop_valid), 32'd0);
        chk("unf_pc_hold", 32'(a_if.pc_out), 32'h10);
        chk("unf_count", 32'(a_if.count), 32'd0);
        op(1'b0, 1'b0, 16'h0, 3'b000, 1'b1);
        chk("unf_clr", 32'(a_if.underflow), 32'd0);

        // Simultaneous push and pop replaces the top
        op(1'b1, 1'b0, 16'h0100, 3'b000, 1'b0);
        op(1'b1, 1'b1, 16'h0200, 3'b000, 1'b0);
        chk("pp_pc", 32'(a_if.pc_out), 32'h100);
        chk("pp_count", 32'(a_if.count), 32'd1);
        chk("pp_pv", 32'(a_if.pop_valid), 32'd1);
        op(1'b0, 1'b1, 16'h0, 3'b000, 1'b0);
        chk("pp_next", 32'(a_if.pc_out), 32'h200);
        chk("pp_empty", 32'(a_if.empty), 32'd1);

        // Flags path
        op(1'b1, 1'b0, 16'h0055, 3'b101, 1'b0);
        op(1'b0, 1'b1, 16'h0, 3'b000, 1'b0);
        chk("fl_pc", 32'(a_if.pc_out), 32'h55);
        chk("fl_out", 32'(a_if.flags_out), 32'(EXP_FL));

        // Overflow: drop vs. wrap
        for (int i = 1; i <= 9; i++) begin
            op(1'b1, 1'b0, 16'(i), 3'b000, 1'b0);
            if (i == 8) begin
                chk("ovf_full8", 32'(a_if.full), 32'd1);
                chk("ovf_not_yet", 32'(a_if.overflow), 32'd0);
            end
        end
        chk("ovf_a_flag", 32'(a_if.overflow), 32'd1);
        chk("ovf_w_flag", 32'(w_if.overflow), 32'd1);
        chk("ovf_a_count", 32'(a_if.count), 32'd8);
        chk("ovf_w_count", 32'(w_if.count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            op(1'b0, 1'b1, 16'h0, 3'b000, 1'b0);
            chk($sformatf("ovf_a_pop%0d", i), 32'(a_if.pc_out), 32'(8 - i));
            chk($sformatf("ovf_w_pop%0d", i), 32'(w_if.pc_out), 32'(9 - i));
        end
        chk("ovf_a_empty", 32'(a_if.empty), 32'd1);

        // err_clr loses to a new underflow in the same cycle, still clears overflow
        op(1'b0, 1'b1, 16'h0, 3'b000, 1'b1);
        chk("clr_unf_wins", 32'(a_if.underflow), 32'd1);
        chk("clr_ovf", 32'(a_if.overflow), 32'd0);
        op(1'b0, 1'b0, 16'h0, 3'b000, 1'b1);
        chk("clr_unf", 32'(a_if.underflow), 32'd0);

        // push&pop on an empty stack acts as a push and flags underflow
        op(1'b1, 1'b1, 16'h0077, 3'b000, 1'b0);
        chk("ppe_count", 32'(a_if.count), 32'd1);
        chk("ppe_unf", 32'(a_if.underflow), 32'd1);
        chk("ppe_pv", 32'(a_if.pop_valid), 32'd0);
        op(1'b0, 1'b1, 16'h0, 3'b000, 1'b0);
        chk("ppe_pop", 32'(a_if.pc_out), 32'h77);

        // Asynchronous reset mid-cycle
        op(1'b1, 1'b0, 16'h0099, 3'b000, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("arst_count", 32'(a_if.count), 32'd0);
        chk("arst_empty", 32'(a_if.empty), 32'd1);
        chk("arst_pc", 32'(a_if.pc_out), 32'd0);
        chk("arst_err", 32'({a_if.overflow, a_if.underflow}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
